seq_cascade_cmp: RTL and testbench
==================================

# seq_cascade_cmp

Parametrised multi-cycle magnitude comparator. Compares two WIDTH-bit operands SLICE bits per clock, least-significant slice first, through a cascadable equal/greater chain. Supports unsigned and two's-complement modes and external cascade inputs, so wide comparisons can be chained across instances. Sits beside the datapath ALU as the shared compare unit for sort/search engines where area matters more than latency.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of SLICE.
- SLICE, 2, bits compared per cycle; 1 ≤ SLICE ≤ WIDTH.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- a  in  WIDTH  operand A, sampled on accepted start.
- b  in  WIDTH  operand B, sampled on accepted start.
- signed_mode  in  1  1 = two's-complement compare; sampled on start.
- e_in  in  1  cascade equal from the less-significant stage; sampled on start.
- g_in  in  1  cascade greater from the less-significant stage; sampled on start.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- eq  out  1  result: A==B, qualified by e_in.
- gt  out  1  result: A>B, or g_in when A==B.
- lt  out  1  result: ~eq & ~gt.

## Operation
- N = WIDTH/SLICE slices; slice k = bits [k*SLICE +: SLICE].
- States IDLE and RUN.
  - IDLE + start: latch a, b, signed_mode, e_in, g_in. Set eq_acc = e_in, gt_acc = g_in, cnt = 0. Go to RUN; busy = 1.
  - RUN, each cycle on slice cnt: if as == bs, the accumulators hold; else eq_acc = 0 and gt_acc = (as > bs) unsigned. Then cnt++.
  - When cnt == N-1 is processed: go to IDLE, pulse done, load eq/gt/lt from the final accumulators.
- Signed mode: invert bit WIDTH-1 of both latched operands before comparing the top slice. No other slice changes.
- Cascade rule per slice matches the 2-bit cell:
  - eq' = (as==bs) ? eq : 0
  - gt' = (as==bs) ? gt : (as>bs)
- eq, gt, lt hold their last result until the next done. They do not change during RUN.
- start while busy = 1 is ignored. Operands and modes are not re-sampled.
- e_in = 1, g_in = 1 is legal: with equal operands the result is eq=1, gt=1, lt=0. The block does not correct this.
- Counter width is max(1, clog2(N)).

## Timing
- Reset (async assert, sync release): state IDLE, busy=0, done=0, eq=0, gt=0, lt=0, cnt=0.
- start accepted at edge T. busy=1 from T through T+N-1.
- done=1 and results valid in the cycle following edge T+N. busy=0 in that same cycle.
- Latency: N cycles start-to-done. Throughput: one compare per N cycles.
- Back-to-back: start asserted in the done cycle is accepted. The new compare begins, and the old results stay on eq/gt/lt until the new done.
- rst mid-RUN aborts immediately. No done is produced, and all outputs return to their reset values.
- SLICE == WIDTH gives N=1: done one cycle after start.

## Structure
- Shared package cmp_pkg:
  - state encoding constants (IDLE, RUN);
  - clog2 function;
  - parameter legality check (WIDTH % SLICE == 0).
- Sub-module cmp_slice: combinational SLICE-bit cascade cell.
  - Inputs: as, bs, eq_i, gt_i, flip_msb.
  - Outputs: eq_o, gt_o.
  - Instantiated once and time-multiplexed over the slices.
- Top level holds the FSM, operand registers, slice mux, counter and result registers.

## Test plan
Scenarios 2–6 use WIDTH=8, SLICE=2.
- Reset: assert rst with random inputs → busy=0, done=0, eq=gt=lt=0. Deassert and idle 10 cycles → outputs unchanged.
- a=0xA5, b=0xA5, e_in=1, g_in=0, unsigned, start at T → done only in the cycle after edge T+4; eq=1, gt=0, lt=0. busy high for exactly 4 cycles.
- a=0xA5, b=0x5A, e_in=1, g_in=0:
  - unsigned → gt=1, eq=0, lt=0;
  - signed_mode=1 (-91 vs 90) → lt=1, gt=0.
- Cascade: a=b=0x12, e_in=0, g_in=1 → eq=0, gt=1. Then a=0x34, b=0x36, e_in=1, g_in=1 → lt=1 (a difference in a lower slice overrides the cascade input).
- Handshake:
  - start pulses during RUN with new operands → ignored, result reflects the original operands;
  - start in the done cycle → accepted, next done exactly 4 cycles later, old result held until then.
- Reset mid-op: start at T, rst pulsed at T+2 → no done ever follows, outputs 0. A fresh start then completes normally in 4 cycles.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential cascade comparator: FSM encoding,
// counter sizing helpers and a parameter legality check.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic bit params_legal(input int width, input int slice);
    return (slice >= 1) && (slice <= width) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational SLICE-bit cascade cell: a difference in this slice overrides
// the incoming equal/greater flags, equality passes them through.
module cmp_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] as,
  input  logic [SLICE-1:0] bs,
  input  logic             eq_i,
  input  logic             gt_i,
  input  logic             flip_msb,
  output logic             eq_o,
  output logic             gt_o
);

  logic [SLICE-1:0] ax;
  logic [SLICE-1:0] bx;

  // NOTE: every signal driven here gets a full default before any partial
  // update, so no path can leave a value held and infer a latch.
  always_comb begin
    ax = as;
    bx = bs;
    // Biasing the sign bit turns a two's-complement compare into an unsigned one.
    ax[SLICE-1] = as[SLICE-1] ^ flip_msb;
    bx[SLICE-1] = bs[SLICE-1] ^ flip_msb;
    eq_o = (ax == bx) ? eq_i : 1'b0;
    gt_o = (ax == bx) ? gt_i : (ax > bx);
  end

endmodule

// File: rtl/seq_cascade_cmp.sv
// Multi-cycle magnitude comparator: walks the operands SLICE bits per clock,
// least-significant slice first, through one shared cascade cell.
module seq_cascade_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             e_in,
  input  logic             g_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(N);

  if (!params_legal(WIDTH, SLICE)) begin : g_bad_params
    $error("seq_cascade_cmp: WIDTH must be a positive multiple of SLICE");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             signed_r;
  logic             eq_acc;
  logic             gt_acc;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [SLICE-1:0] as;
  logic [SLICE-1:0] bs;
  logic             eq_nx;
  logic             gt_nx;

  assign busy = (state == RUN);
  assign last = (cnt == CW'(N - 1));
  assign as   = a_r[int'(cnt) * SLICE +: SLICE];
  assign bs   = b_r[int'(cnt) * SLICE +: SLICE];

  cmp_slice #(.SLICE(SLICE)) u_slice (
    .as       (as),
    .bs       (bs),
    .eq_i     (eq_acc),
    .gt_i     (gt_acc),
    .flip_msb (signed_r & last),
    .eq_o     (eq_nx),
    .gt_o     (gt_nx)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: operand registers are reset too; they are few flops and keeping them
  // deterministic avoids X propagation into the cascade after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      signed_r <= 1'b0;
      eq_acc   <= 1'b0;
      gt_acc   <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
      lt       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            signed_r <= signed_mode;
            eq_acc   <= e_in;
            gt_acc   <= g_in;
            cnt      <= '0;
          end
        end
        RUN: begin
          eq_acc <= eq_nx;
          gt_acc <= gt_nx;
          cnt    <= cnt + CW'(1);
          if (last) begin
            cnt  <= '0;
            done <= 1'b1;
            eq   <= eq_nx;
            gt   <= gt_nx;
            lt   <= ~eq_nx & ~gt_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cascade_cmp.sv
// Scoreboard bench for seq_cascade_cmp (WIDTH=8, SLICE=2): directed scenarios
// plus random compares checked against an integer-arithmetic reference.
module tb_seq_cascade_cmp;

  localparam int WIDTH = 8;
  localparam int SLICE = 2;
  localparam int N     = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             signed_mode = 1'b0;
  logic             e_in = 1'b0;
  logic             g_in = 1'b0;
  logic             busy, done, eq, gt, lt;

  int        compared   = 0;
  int        mismatched = 0;
  int        cyc        = 0;
  logic [2:0] exp_q[$];
  logic [2:0] held = 3'b000;

  seq_cascade_cmp #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .e_in        (e_in),
    .g_in        (g_in),
    .busy        (busy),
    .done        (done),
    .eq          (eq),
    .gt          (gt),
    .lt          (lt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: compare the whole operands as integers, then apply the cascade inputs on a tie.
  function automatic logic [2:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                       input bit sm, input bit e, input bit g);
    int xi, yi;
    bit r_eq, r_gt;
    xi = sm ? int'($signed(x)) : int'(x);
    yi = sm ? int'($signed(y)) : int'(y);
    r_eq = (xi == yi) && e;
    r_gt = (xi > yi) || ((xi == yi) && g);
    return {r_eq, r_gt, !r_eq && !r_gt};
  endfunction

  // Monitor: pops on every done, otherwise the results must hold.
  always @(negedge clk) begin
    if (rst) begin
      held = 3'b000;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        held = exp_q.pop_front();
        check("result", 32'({eq, gt, lt}), 32'(held));
      end
    end else begin
      check("result_hold", 32'({eq, gt, lt}), 32'(held));
    end
  end

  int t0;

  // Called at a negedge with the DUT idle; returns just after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input bit sm, input bit e, input bit g);
    check("idle_before_start", 32'(busy), 32'd0);
    a = x; b = y; signed_mode = sm; e_in = e; g_in = g; start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    exp_q.push_back(model(x, y, sm, e, g));
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    signed_mode = 1'($urandom); e_in = 1'($urandom); g_in = 1'($urandom);
  endtask

  // Waits (bounded) for done; optionally pokes start with junk operands while busy.
  task automatic wait_done(input bit poke, output int lat, output int bcnt);
    bit seen;
    seen = 1'b0;
    bcnt = 0;
    lat  = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = cyc - t0;
        break;
      end
      if (busy) bcnt++;
      if (poke) begin
        start = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
        signed_mode = 1'($urandom); e_in = 1'($urandom); g_in = 1'($urandom);
      end
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    else       check("done_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, bcnt, dones;
    bit b2b;

    // Reset with random inputs applied.
    a = WIDTH'($urandom); b = WIDTH'($urandom); start = 1'($urandom);
    e_in = 1'($urandom); g_in = 1'($urandom); signed_mode = 1'($urandom);
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({busy, done, eq, gt, lt}), 32'd0);
    start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_outputs", 32'({busy, done, eq, gt, lt}), 32'd0);

    // Equal operands, latency and busy width.
    launch(8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, lat, bcnt);
    check("a5_eq_latency", 32'(lat), 32'(N));
    check("a5_eq_busy_cycles", 32'(bcnt), 32'(N));
    check("a5_eq_result", 32'({eq, gt, lt}), 32'b100);

    @(negedge clk);
    launch(8'hA5, 8'h5A, 1'b0, 1'b1, 1'b0);
    wait_done(1'b0, lat, bcnt);
    check("a5_5a_unsigned", 32'({eq, gt, lt}), 32'b010);

    @(negedge clk);
    launch(8'hA5, 8'h5A, 1'b1, 1'b1, 1'b0);
    wait_done(1'b0, lat, bcnt);
    check("a5_5a_signed", 32'({eq, gt, lt}), 32'b001);

    // Cascade inputs: decide only on a tie.
    @(negedge clk);
    launch(8'h12, 8'h12, 1'b0, 1'b0, 1'b1);
    wait_done(1'b0, lat, bcnt);
    check("cascade_tie_gt", 32'({eq, gt, lt}), 32'b010);

    @(negedge clk);
    launch(8'h34, 8'h36, 1'b0, 1'b1, 1'b1);
    wait_done(1'b0, lat, bcnt);
    check("cascade_low_slice_lt", 32'({eq, gt, lt}), 32'b001);

    // Start pulses during RUN are ignored.
    @(negedge clk);
    launch(8'h80, 8'h7F, 1'b1, 1'b1, 1'b0);
    wait_done(1'b1, lat, bcnt);
    check("ignored_start_latency", 32'(lat), 32'(N));
    check("ignored_start_result", 32'({eq, gt, lt}), 32'b001);

    // Back-to-back: start in the done cycle; old result held until next done.
    launch(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, lat, bcnt);
    check("b2b_latency", 32'(lat), 32'(N));
    check("b2b_result", 32'({eq, gt, lt}), 32'b010);

    // Reset mid-operation.
    @(negedge clk);
    launch(8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midop_rst_outputs", 32'({busy, done, eq, gt, lt}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midop_no_done", 32'(dones), 32'd0);
    check("midop_outputs_zero", 32'({busy, eq, gt, lt}), 32'd0);

    launch(8'hC3, 8'hC3, 1'b1, 1'b1, 1'b1);
    wait_done(1'b0, lat, bcnt);
    check("post_rst_latency", 32'(lat), 32'(N));
    check("post_rst_both_cascade", 32'({eq, gt, lt}), 32'b110);

    // Random compares, mixing idle gaps and back-to-back starts.
    b2b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!b2b) @(negedge clk);
      launch(WIDTH'($urandom), (($urandom_range(0, 3) == 0) ? a ^ WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom)),
             1'($urandom), 1'($urandom), 1'($urandom));
      wait_done(1'($urandom), lat, bcnt);
      check("rand_latency", 32'(lat), 32'(N));
      b2b = 1'($urandom);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
